// File: rtl/vga_pkg.sv
// Shared framebuffer geometry and the CPU request record used by the arbiter and its queue.
package vga_pkg;

  localparam int unsigned TILE_COLS  = 80;
  localparam int unsigned TILE_ROWS  = 60;
  localparam int unsigned TILE_SHIFT = 3;
  localparam int unsigned FB_WORDS   = TILE_COLS * TILE_ROWS;
  localparam int unsigned FB_ADDR_W  = 13;
  localparam int unsigned COLOR_W    = 12;

  typedef struct packed {
    logic                 we;
    logic [FB_ADDR_W-1:0] addr;
    logic [COLOR_W-1:0]   wdata;
  } fb_req_t;

  typedef enum logic {StIdle, StClear} clr_state_e;

endpackage

// File: rtl/fb_req_fifo.sv
// Synchronous FIFO holding queued CPU framebuffer requests.
module fb_req_fifo import vga_pkg::*; #(
  parameter int unsigned DEPTH = 4
) (
  input  logic    clk,
  input  logic    rst,
  input  logic    push,
  input  fb_req_t wdata,
  input  logic    pop,
  output fb_req_t rdata,
  output logic    full,
  output logic    empty
);

  localparam int unsigned PtrW = $clog2(DEPTH);

  fb_req_t         mem_q [DEPTH];
  logic [PtrW:0]   wr_ptr_q, rd_ptr_q;
  logic            push_ok, pop_ok;

  // Extra pointer bit distinguishes full from empty when the indices match.
  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[PtrW] != rd_ptr_q[PtrW]) &&
                   (wr_ptr_q[PtrW-1:0] == rd_ptr_q[PtrW-1:0]);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign rdata   = mem_q[rd_ptr_q[PtrW-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q[PtrW-1:0]] <= wdata;
  end

endmodule

// File: rtl/vga_fb_arbiter.sv
// Framebuffer RAM arbiter: VGA tile fetch has absolute priority, then the
// frame-clear engine, then the queued CPU read/write port.
module vga_fb_arbiter #(
  parameter int unsigned TILE_COLS  = vga_pkg::TILE_COLS,
  parameter int unsigned TILE_ROWS  = vga_pkg::TILE_ROWS,
  parameter int unsigned ADDR_W     = vga_pkg::FB_ADDR_W,
  parameter int unsigned COLOR_W    = vga_pkg::COLOR_W,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [10:0]        vga_x,
  input  logic [10:0]        vga_y,
  input  logic               vga_de,
  output logic [COLOR_W-1:0] vga_color,
  input  logic               cpu_req_valid,
  output logic               cpu_req_ready,
  input  logic               cpu_req_we,
  input  logic [ADDR_W-1:0]  cpu_req_addr,
  input  logic [COLOR_W-1:0] cpu_req_wdata,
  output logic               cpu_rsp_valid,
  output logic [COLOR_W-1:0] cpu_rsp_rdata,
  input  logic               clear_start,
  input  logic [COLOR_W-1:0] clear_color,
  output logic               clear_busy,
  output logic               ram_en,
  output logic               ram_we,
  output logic [ADDR_W-1:0]  ram_addr,
  output logic [COLOR_W-1:0] ram_wdata,
  input  logic [COLOR_W-1:0] ram_rdata
);

  import vga_pkg::*;

  localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(TILE_COLS * TILE_ROWS - 1);

  clr_state_e         clr_state_q, clr_state_d;
  logic [ADDR_W-1:0]  clr_addr_q, clr_addr_d;
  logic [COLOR_W-1:0] clr_color_q, clr_color_d;
  logic               rsp_pend_q, rsp_pend_d;
  logic               rsp_oob_q, rsp_oob_d;
  logic               vga_rd_q;
  logic [COLOR_W-1:0] color_hold_q;

  logic               vga_slot;
  logic [13:0]        row_w, col_w, vga_sum;
  logic [ADDR_W-1:0]  vga_addr;
  fb_req_t            req_in, req_head;
  logic               fifo_full, fifo_empty, fifo_push, fifo_pop;
  logic               head_oob;
  logic               unused_vga;

  assign vga_slot = vga_de && (vga_x[TILE_SHIFT-1:0] == '0);

  // row*80 + col as shift-and-add
  assign row_w    = 14'(vga_y[9:TILE_SHIFT]);
  assign col_w    = 14'(vga_x[9:TILE_SHIFT]);
  assign vga_sum  = (row_w << 6) + (row_w << 4) + col_w;
  assign vga_addr = vga_sum[ADDR_W-1:0];

  assign unused_vga = ^{vga_x[10], vga_y[10], vga_y[TILE_SHIFT-1:0], vga_sum[13]};

  assign req_in    = '{we: cpu_req_we, addr: cpu_req_addr, wdata: cpu_req_wdata};
  assign fifo_push = cpu_req_valid && !fifo_full;
  assign head_oob  = req_head.addr > LastAddr;

  fb_req_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_req_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .wdata (req_in),
    .pop   (fifo_pop),
    .rdata (req_head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_comb begin
    ram_en      = 1'b0;
    ram_we      = 1'b0;
    ram_addr    = '0;
    ram_wdata   = '0;
    fifo_pop    = 1'b0;
    rsp_pend_d  = 1'b0;
    rsp_oob_d   = 1'b0;
    clr_state_d = clr_state_q;
    clr_addr_d  = clr_addr_q;
    clr_color_d = clr_color_q;

    if (clr_state_q == StIdle && clear_start) begin
      clr_state_d = StClear;
      clr_addr_d  = '0;
      clr_color_d = clear_color;
    end

    // Keep the RAM quiet while reset is held.
    if (!rst) begin
      if (vga_slot) begin
        ram_en   = 1'b1;
        ram_addr = vga_addr;
      end else if (clr_state_q == StClear) begin
        ram_en    = 1'b1;
        ram_we    = 1'b1;
        ram_addr  = clr_addr_q;
        ram_wdata = clr_color_q;
        if (clr_addr_q == LastAddr) begin
          clr_state_d = StIdle;
        end else begin
          clr_addr_d = clr_addr_q + 1'b1;
        end
      end else if (!fifo_empty) begin
        fifo_pop   = 1'b1;
        rsp_pend_d = !req_head.we;
        rsp_oob_d  = head_oob;
        if (!head_oob) begin
          ram_en    = 1'b1;
          ram_we    = req_head.we;
          ram_addr  = req_head.addr;
          ram_wdata = req_head.wdata;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      clr_state_q  <= StIdle;
      clr_addr_q   <= '0;
      clr_color_q  <= '0;
      rsp_pend_q   <= 1'b0;
      rsp_oob_q    <= 1'b0;
      vga_rd_q     <= 1'b0;
      color_hold_q <= '0;
    end else begin
      clr_state_q <= clr_state_d;
      clr_addr_q  <= clr_addr_d;
      clr_color_q <= clr_color_d;
      rsp_pend_q  <= rsp_pend_d;
      rsp_oob_q   <= rsp_oob_d;
      vga_rd_q    <= vga_slot;
      if (vga_rd_q) color_hold_q <= ram_rdata;
    end
  end

  assign vga_color     = vga_rd_q ? ram_rdata : color_hold_q;
  assign cpu_req_ready = !fifo_full;
  assign cpu_rsp_valid = rsp_pend_q && !rst;
  assign cpu_rsp_rdata = rsp_oob_q ? '0 : ram_rdata;
  assign clear_busy    = (clr_state_q == StClear);

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Scoreboard bench for vga_fb_arbiter: random CPU/VGA traffic, frame clears and resets.
module tb_vga_fb_arbiter;

  localparam int NW = 4800;

  typedef struct {
    logic        we;
    logic [12:0] addr;
    logic [11:0] data;
  } acc_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [10:0] vga_x = '0, vga_y = '0;
  logic        vga_de = 1'b0;
  logic [11:0] vga_color;
  logic        cpu_req_valid = 1'b0, cpu_req_ready, cpu_req_we = 1'b0;
  logic [12:0] cpu_req_addr = '0;
  logic [11:0] cpu_req_wdata = '0;
  logic        cpu_rsp_valid;
  logic [11:0] cpu_rsp_rdata;
  logic        clear_start = 1'b0;
  logic [11:0] clear_color = '0;
  logic        clear_busy;
  logic        ram_en, ram_we;
  logic [12:0] ram_addr;
  logic [11:0] ram_wdata;
  logic [11:0] ram_rdata = '0;

  logic [11:0] ram_mem   [NW];
  logic [11:0] mem_model [NW];
  logic [11:0] pre_model [NW];

  acc_t        acc_q[$];
  logic [11:0] rsp_q[$];
  int          checks = 0;
  int          fails = 0;
  int          busy_cycles = 0;
  logic        vga_rand = 1'b0;

  // checker state
  logic        slot_prev = 1'b0;
  logic [11:0] snap = '0, exp_color = '0, clr_color = '0;
  logic        clr_active = 1'b0;
  int          clr_next = 0;
  int          clr_stop_at = 0;

  always #5 clk = ~clk;

  vga_fb_arbiter dut (
    .clk           (clk),
    .rst           (rst),
    .vga_x         (vga_x),
    .vga_y         (vga_y),
    .vga_de        (vga_de),
    .vga_color     (vga_color),
    .cpu_req_valid (cpu_req_valid),
    .cpu_req_ready (cpu_req_ready),
    .cpu_req_we    (cpu_req_we),
    .cpu_req_addr  (cpu_req_addr),
    .cpu_req_wdata (cpu_req_wdata),
    .cpu_rsp_valid (cpu_rsp_valid),
    .cpu_rsp_rdata (cpu_rsp_rdata),
    .clear_start   (clear_start),
    .clear_color   (clear_color),
    .clear_busy    (clear_busy),
    .ram_en        (ram_en),
    .ram_we        (ram_we),
    .ram_addr      (ram_addr),
    .ram_wdata     (ram_wdata),
    .ram_rdata     (ram_rdata)
  );

  // Single-port RAM, one-cycle read latency.
  always @(posedge clk) begin
    if (ram_en && int'(ram_addr) < NW) begin
      if (ram_we) ram_mem[ram_addr] <= ram_wdata;
      else        ram_rdata <= ram_mem[ram_addr];
    end
  end

  task automatic check(input string name, input int unsigned act, input int unsigned exp);
    checks++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) if (clear_busy) busy_cycles++;

  always @(posedge clk) begin
    if (vga_rand) begin
      #1;
      vga_de = ($urandom_range(0, 3) != 0);
      vga_x  = ($urandom_range(0, 1) != 0) ? 11'($urandom_range(0, 79) * 8)
                                            : 11'($urandom_range(0, 639));
      vga_y  = 11'($urandom_range(0, 479));
    end
  end

  // Monitor: compares every RAM access and response against the expectation queues.
  always @(negedge clk) begin
    logic slot, was_active;
    int   exp_addr;
    acc_t a;
    if (rst) begin
      acc_q.delete();
      rsp_q.delete();
      slot_prev = 1'b0;
      exp_color = '0;
      if (clr_active) clr_stop_at = clr_next;
      clr_active = 1'b0;
    end else begin
      slot = vga_de && (vga_x[2:0] == 3'd0);
      was_active = clr_active;
      if (slot_prev) exp_color = snap;
      check("vga_color", vga_color, exp_color);
      check("clear_busy", clear_busy, clr_active);
      if (slot) begin
        exp_addr = (int'(vga_y[9:0]) / 8) * 80 + int'(vga_x[9:0]) / 8;
        check("vga_access", {ram_en, ram_we}, 2'b10);
        check("vga_addr", ram_addr, exp_addr);
        snap = ram_mem[exp_addr];
      end else if (clr_active) begin
        check("clr_access", {ram_en, ram_we}, 2'b11);
        check("clr_addr", ram_addr, clr_next);
        check("clr_data", ram_wdata, clr_color);
        clr_next++;
        if (clr_next == NW) clr_active = 1'b0;
      end else if (ram_en) begin
        check("cpu_access_expected", acc_q.size() > 0, 1);
        if (acc_q.size() > 0) begin
          a = acc_q.pop_front();
          check("cpu_we", ram_we, a.we);
          check("cpu_addr", ram_addr, a.addr);
          if (a.we) check("cpu_wdata", ram_wdata, a.data);
        end
      end
      if (cpu_rsp_valid) begin
        check("rsp_expected", rsp_q.size() > 0, 1);
        if (rsp_q.size() > 0) check("rsp_rdata", cpu_rsp_rdata, rsp_q.pop_front());
      end
      if (clear_start && !was_active) begin
        clr_active = 1'b1;
        clr_next   = 0;
        clr_color  = clear_color;
      end
      slot_prev = slot;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one request; the expectation is queued when the handshake is seen.
  task automatic cpu_req(input logic we, input logic [12:0] addr, input logic [11:0] data);
    int   guard = 0;
    acc_t a;
    cpu_req_valid = 1'b1;
    cpu_req_we    = we;
    cpu_req_addr  = addr;
    cpu_req_wdata = data;
    @(negedge clk);
    while (!cpu_req_ready && guard < 10000) begin
      @(negedge clk);
      guard++;
    end
    check("req_ready_wait", cpu_req_ready, 1);
    if (cpu_req_ready) begin
      if (int'(addr) < NW) begin
        a.we = we;
        a.addr = addr;
        a.data = data;
        acc_q.push_back(a);
        if (we) mem_model[addr] = data;
        else    rsp_q.push_back(mem_model[addr]);
      end else if (!we) begin
        rsp_q.push_back(12'h000);
      end
    end
    @(posedge clk);
    #1;
    cpu_req_valid = 1'b0;
  endtask

  task automatic drain(input int bound);
    int n = 0;
    while ((acc_q.size() != 0 || rsp_q.size() != 0) && n < bound) begin
      @(negedge clk);
      n++;
    end
    check("drain", acc_q.size() + rsp_q.size(), 0);
    @(posedge clk);
    #1;
  endtask

  task automatic random_traffic(input int count);
    int unsigned r;
    for (int i = 0; i < count; i++) begin
      repeat ($urandom_range(0, 2)) tick();
      r = $urandom_range(0, 99);
      cpu_req(1'($urandom_range(0, 1)),
              (r < 10) ? 13'(NW + $urandom_range(0, 100)) : 13'($urandom_range(0, 63)),
              12'($urandom));
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          n;
    int          bad;
    logic [11:0] c2, e;

    for (int i = 0; i < NW; i++) begin
      ram_mem[i]  <= 12'h000;
      mem_model[i] = 12'h000;
    end
    ram_mem[81]  <= 12'hF00;
    mem_model[81] = 12'hF00;

    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("rst_ready", cpu_req_ready, 1);
    check("rst_ram_en", ram_en, 0);
    check("rst_ram_we", ram_we, 0);
    check("rst_rsp_valid", cpu_rsp_valid, 0);
    check("rst_vga_color", vga_color, 0);
    tick();

    // Tile (1,1) fetch and hold across the tile width.
    vga_de = 1'b1;
    vga_y  = 11'd8;
    for (int x = 8; x < 16; x++) begin
      vga_x = 11'(x);
      tick();
    end
    vga_de = 1'b0;
    @(negedge clk);
    check("tile_color_held", vga_color, 12'hF00);
    tick();

    // Write whose issue cycle collides with a VGA slot.
    cpu_req(1'b1, 13'd5, 12'h0A5);
    vga_de = 1'b1;
    vga_x  = 11'd0;
    vga_y  = 11'd0;
    tick();
    vga_de = 1'b0;
    drain(8);

    // Fill the queue while VGA slots starve the CPU.
    vga_de = 1'b1;
    vga_x  = 11'd8;
    vga_y  = 11'd8;
    for (int i = 0; i < 4; i++) cpu_req(1'b1, 13'(100 + i), 12'($urandom));
    @(negedge clk);
    check("fifo_full_ready", cpu_req_ready, 0);
    tick();
    vga_de = 1'b0;
    cpu_req(1'b1, 13'd104, 12'($urandom));
    drain(12);

    cpu_req(1'b0, 13'd4800, 12'h000);
    cpu_req(1'b0, 13'd5, 12'h000);
    cpu_req(1'b0, 13'd81, 12'h000);
    cpu_req(1'b0, 13'd102, 12'h000);
    drain(16);

    vga_rand = 1'b1;
    random_traffic(300);
    drain(64);
    vga_rand = 1'b0;
    tick();
    vga_de = 1'b0;
    tick();

    // Full clear with CPU traffic queued behind it.
    for (int i = 0; i < NW; i++) mem_model[i] = 12'h123;
    busy_cycles = 0;
    clear_color = 12'h123;
    clear_start = 1'b1;
    tick();
    clear_start = 1'b0;
    cpu_req(1'b1, 13'd7, 12'h456);
    cpu_req(1'b0, 13'd7, 12'h000);
    cpu_req(1'b0, 13'd9, 12'h000);
    clear_color = 12'hFFF;
    clear_start = 1'b1;
    tick();
    clear_start = 1'b0;
    n = 0;
    while (clear_busy && n < 6000) begin
      @(negedge clk);
      n++;
    end
    check("clear_done", clear_busy, 0);
    check("clear_busy_cycles", busy_cycles, NW);
    tick();
    drain(32);
    bad = 0;
    for (int i = 0; i < NW; i++) if (ram_mem[i] !== mem_model[i]) bad++;
    check("ram_after_clear", bad, 0);

    // Clear interrupted by reset under VGA traffic.
    for (int i = 0; i < NW; i++) pre_model[i] = mem_model[i];
    c2 = 12'($urandom_range(1, 4094));
    vga_rand = 1'b1;
    clear_color = c2;
    clear_start = 1'b1;
    tick();
    clear_start = 1'b0;
    repeat (1500) tick();
    vga_rand = 1'b0;
    tick();
    vga_de = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("rst_clear_busy", clear_busy, 0);
    check("rst_clear_ram_en", ram_en, 0);
    check("rst_clear_rsp", cpu_rsp_valid, 0);
    check("rst_clear_ready", cpu_req_ready, 1);
    check("clear_interrupted", (clr_stop_at > 0) && (clr_stop_at < NW), 1);
    bad = 0;
    for (int i = 0; i < NW; i++) begin
      e = (i < clr_stop_at) ? c2 : pre_model[i];
      if (ram_mem[i] !== e) bad++;
      mem_model[i] = e;
    end
    check("partial_fill", bad, 0);
    tick();

    // Reset while a read response is in flight.
    cpu_req(1'b0, 13'd7, 12'h000);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("rst_read_rsp", cpu_rsp_valid, 0);
    check("rst_read_busy", clear_busy, 0);
    check("rst_read_ram_en", ram_en, 0);
    check("rst_read_ready", cpu_req_ready, 1);
    tick();

    vga_rand = 1'b1;
    random_traffic(100);
    drain(64);
    vga_rand = 1'b0;
    tick();

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
